bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares the processor's single 16-bit internal bus among up to NREQ requesters (register-file read port, ALU result, memory load path, immediate unit). It registers a one-hot grant and an encoded select, and drives the bus from the granted requester's data through the shared data-select multiplexer. Ownership is held until the owner releases it. An optional hold-limit timeout enforces fairness.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 16, bus data width
- MAX_HOLD, 16, maximum consecutive GRANT cycles per ownership (timeout build only; ≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- req  input  NREQ  per-requester request; held high for the whole ownership
- req_data  input  NREQ*DW  packed requester data; slice i = [i*DW +: DW]
- gnt  output  NREQ  registered one-hot grant; all-zero when bus idle
- gnt_sel  output  SELW  registered encoded owner index; SELW = clog2(NREQ)
- bus_data  output  DW  req_data slice selected by gnt_sel when bus_valid, else 0
- bus_valid  output  1  high exactly when any gnt bit is high
- busy  output  1  high in GRANT or RELEASE
- preempt  output  1  one-cycle pulse when an owner loses the bus by timeout

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is non-zero, pick the winner: first set bit searching upward from last_owner+1 with wrap.
  - Register gnt, gnt_sel and last_owner; go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT:
  - Hold gnt.
  - Requests from non-owners are ignored.
  - If req[gnt_sel] = 0, clear gnt and go to RELEASE.
  - If the timeout fires (see Configuration), clear gnt, pulse preempt and go to RELEASE.
- RELEASE:
  - One dead bus cycle with gnt = 0 (turnaround).
  - Arbitrate exactly as in IDLE. If there is a winner, go to GRANT; else go to IDLE.
- Fairness:
  - The previous owner has lowest priority at the next arbitration.
  - The previous owner is regranted only if no other requester is pending.
- Reset values:
  - state = IDLE
  - gnt = 0, gnt_sel = 0
  - last_owner = NREQ-1, so requester 0 has first priority
  - hold counter = 0
  - bus_valid, busy, preempt = 0
  - bus_data = 0
- Reset asserted mid-GRANT clears all of the above immediately, asynchronously; no partial transfer is completed.
- bus_data is combinational from the registered gnt_sel and the live req_data. It is zero-forced when bus_valid = 0.

## Timing
- Grant latency: req rising while IDLE → gnt high at the next clk edge (1 cycle). bus_valid and bus_data are valid in that same cycle.
- Release: owner drops req at edge k → gnt low after edge k+1.
  - The cycle following edge k+1 is RELEASE.
  - The earliest new gnt is after edge k+2.
  - Exactly one idle bus cycle separates owners.
- A request that rises and falls while another requester owns the bus is lost. Requesters hold req until they see gnt.
- Simultaneous release and new request: arbitration happens in RELEASE, so no extra cycle is added.
- preempt is high only during the RELEASE cycle that follows a timeout.

## Configuration
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A hold counter (width clog2(MAX_HOLD)) clears on entering GRANT and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and req[gnt_sel] is still high, the timeout fires.
  - An owner therefore holds the bus at most MAX_HOLD cycles.
- Undefined:
  - No counter is built.
  - preempt is tied to 0.
  - Ownership is unbounded.

## Structure
- Package bus_arb_pkg holds:
  - state encoding (IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2)
  - default NREQ and DW
  - SELW derivation
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req and last_owner.
  - Outputs: found, winner index and one-hot winner.
  - It is instantiated once and used in both IDLE and RELEASE.
- The bus data select reuses the codebase's existing multiplexer style, indexed by gnt_sel.

## Test plan
- Reset, then req = 4'b0001 with slice0 = 16'hA5A5 → gnt = 0001, gnt_sel = 0, bus_data = A5A5 one cycle after req.
- req = 4'b1111 held constant (timeout build, MAX_HOLD = 4; each owner drops after 2 cycles) → grant order 0,1,2,3,0 with one dead cycle between each.
- Owner 2 holds req for 10 cycles, with BUS_ARBITER_TIMEOUT_EN and MAX_HOLD = 4 → gnt cleared after 4 cycles; preempt pulses once; pending requester 3 granted next; owner 2 is regranted only after requester 3 releases.
- Same stimulus without the macro → owner 2 holds the bus for all 10 cycles; preempt stays 0.
- Requester 1 pulses req for 1 cycle during requester 0's ownership → no grant to 1; bus returns to IDLE after 0 releases.
- rst_n driven low mid-GRANT (asynchronous to clk) → gnt, bus_valid and busy are 0 immediately. After reset release with req = 4'b1010, requester 1 wins first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding,
// default sizes and the select-width helper.
package bus_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Encoded-index width; never below one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above
// last_owner+1, searching upward with wrap-around.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SELW = sel_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last_owner,
  output logic            found,
  output logic [SELW-1:0] winner,
  output logic [NREQ-1:0] winner_oh
);

  assign found = |req;

  // Walk from the farthest candidate to the nearest so the nearest
  // pending requester after last_owner is the final assignment.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    winner = '0;
    idx    = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(last_owner) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[SELW-1:0]]) winner = idx[SELW-1:0];
    end
  end

  always_comb begin
    winner_oh = '0;
    if (found) winner_oh[winner] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner-holds arbiter for the shared internal bus.
// Optional hold-limit timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ     = NREQ_DEF,
  parameter  int DW       = DW_DEF,
  parameter  int MAX_HOLD = 16,
  localparam int SELW     = sel_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [SELW-1:0]   gnt_sel,
  output logic [DW-1:0]     bus_data,
  output logic              bus_valid,
  output logic              busy,
  output logic              preempt
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_d;
  logic [SELW-1:0] sel_d;
  logic [SELW-1:0] last_q, last_d;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            owner_req;
  logic            timeout;

  rr_pick #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .found      (pick_found),
    .winner     (pick_idx),
    .winner_oh  (pick_oh)
  );

  assign owner_req = req[gnt_sel];

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD);

  logic [HCW-1:0] hold_cnt;
  logic           preempt_q;

  assign timeout = (state_q == GRANT) && owner_req &&
                   (hold_cnt == HCW'(MAX_HOLD - 1));

  // Counter idles at zero outside GRANT, so it is clear on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_cnt  <= (state_q == GRANT) ? hold_cnt + 1'b1 : '0;
      preempt_q <= timeout;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = gnt_sel;
    last_d  = last_q;
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (pick_found) begin
          gnt_d   = pick_oh;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Non-owner requests are ignored until the owner lets go.
        if (!owner_req || timeout) begin
          gnt_d   = '0;
          state_d = RELEASE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_sel <= '0;
      last_q  <= SELW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_sel <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus_valid = |gnt;
  assign busy      = (state_q != IDLE);
  assign bus_data  = bus_valid ? req_data[int'(gnt_sel) * DW +: DW] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ=4, DW=16, MAX_HOLD=4).
// Expectations follow BUS_ARBITER_TIMEOUT_EN when it is defined.
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_sel;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic        busy;
  logic        preempt;

  int passed = 0;
  int total  = 0;

  bus_arbiter #(
    .NREQ     (4),
    .DW       (16),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .gnt_sel   (gnt_sel),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .busy      (busy),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};
    #3;
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (gnt_sel !== 2'd0) $display("FAIL reset_sel: got %0d expected 0", gnt_sel); else passed++;
    total++; if (bus_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (preempt !== 1'b0) $display("FAIL reset_preempt: got %b expected 0", preempt); else passed++;
    total++; if (bus_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", bus_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_grant();
    req = 4'b0001;
    #1;
    total++; if (gnt !== 4'b0000) $display("FAIL basic_pre_edge: got %b expected 0000", gnt); else passed++;
    step();
    total++; if (gnt !== 4'b0001) $display("FAIL basic_gnt: got %b expected 0001", gnt); else passed++;
    total++; if (gnt_sel !== 2'd0) $display("FAIL basic_sel: got %0d expected 0", gnt_sel); else passed++;
    total++; if (bus_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bus_valid); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else passed++;
    total++; if (bus_data !== 16'hA5A5) $display("FAIL basic_data: got %h expected a5a5", bus_data); else passed++;
    req_data[15:0] = 16'h5A5A;
    #1;
    total++; if (bus_data !== 16'h5A5A) $display("FAIL basic_live_data: got %h expected 5a5a", bus_data); else passed++;
    req = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000) $display("FAIL basic_release_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL basic_release_busy: got %b expected 1", busy); else passed++;
    total++; if (bus_data !== 16'h0000) $display("FAIL basic_release_data: got %h expected 0000", bus_data); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", busy); else passed++;
    req_data[15:0] = 16'hA5A5;
  endtask

  task automatic test_round_robin();
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] slice [4] = '{16'hA5A5, 16'h1111, 16'h2222, 16'h3333};
    logic [3:0]  exp_oh;
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << order[k];
      total++; if (gnt !== exp_oh) $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_oh); else passed++;
      total++; if (gnt_sel !== 2'(order[k])) $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, gnt_sel, order[k]); else passed++;
      total++; if (bus_data !== slice[order[k]]) $display("FAIL rr_data[%0d]: got %h expected %h", k, bus_data, slice[order[k]]); else passed++;
      step();
      total++; if (gnt !== exp_oh) $display("FAIL rr_hold[%0d]: got %b expected %b", k, gnt, exp_oh); else passed++;
      req[order[k]] = 1'b0;
      step();
      total++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL rr_dead[%0d]: got gnt %b busy %b expected 0000 1", k, gnt, busy); else passed++;
      req[order[k]] = 1'b1;
      step();
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_hold_limit();
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [3:0] exp_gnt [15] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0,
                                 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       exp_pre [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    logic [3:0] exp_gnt [15] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
                                 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
    logic       exp_pre [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    int seen3 = 0;
    do_reset();
    req = 4'b0100;
    for (int e = 1; e <= 15; e++) begin
      step();
      total++; if (gnt !== exp_gnt[e-1]) $display("FAIL hold_gnt[e%0d]: got %b expected %b", e, gnt, exp_gnt[e-1]); else passed++;
      total++; if (preempt !== exp_pre[e-1]) $display("FAIL hold_preempt[e%0d]: got %b expected %b", e, preempt, exp_pre[e-1]); else passed++;
      if (gnt[3]) seen3++;
      if (e == 1) req[3] = 1'b1;
      if (seen3 == 2) req[3] = 1'b0;
      if (e == 10) req[2] = 1'b0;
    end
    total++; if (busy !== 1'b0) $display("FAIL hold_final_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_lost_pulse();
    do_reset();
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001) $display("FAIL lost_owner: got %b expected 0001", gnt); else passed++;
    req = 4'b0011;
    step();
    total++; if (gnt !== 4'b0001) $display("FAIL lost_ignore: got %b expected 0001", gnt); else passed++;
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001) $display("FAIL lost_keep: got %b expected 0001", gnt); else passed++;
    req = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL lost_release: got gnt %b busy %b expected 0000 1", gnt, busy); else passed++;
    step();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL lost_idle: got gnt %b busy %b expected 0000 0", gnt, busy); else passed++;
    step();
    total++; if (bus_valid !== 1'b0) $display("FAIL lost_no_grant: got %b expected 0", bus_valid); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001) $display("FAIL arst_pre_gnt: got %b expected 0001", gnt); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) $display("FAIL arst_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (bus_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", bus_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else passed++;
    total++; if (bus_data !== 16'h0000) $display("FAIL arst_data: got %h expected 0000", bus_data); else passed++;
    req = 4'b1010;
    #2;
    rst_n = 1'b1;
    step();
    total++; if (gnt !== 4'b0010) $display("FAIL arst_first_gnt: got %b expected 0010", gnt); else passed++;
    total++; if (gnt_sel !== 2'd1) $display("FAIL arst_first_sel: got %0d expected 1", gnt_sel); else passed++;
    total++; if (bus_data !== 16'h1111) $display("FAIL arst_first_data: got %h expected 1111", bus_data); else passed++;
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_hold_limit();
    test_lost_pulse();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
